// File: rtl/adc_conv_ctrl.sv
// adc_conv_ctrl
// Conversion sequencer for the soft ADCs (PWM-DAC and R2R-DAC paths).
// It drives a trial code into the DAC, waits SETTLE_CYCLES for the DAC and
// comparator synchronizer to settle, then samples the comparator.  The input
// is resolved either by a linear ramp from zero or by successive approximation.
//
// Parameters:
//   WIDTH          DAC/result resolution in bits (2..12)
//   SETTLE_CYCLES  clocks waited after each dac_code change (>=3)
//
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset
//   en            block enable from mode selector; low forces IDLE
//   sar_mode      1 = SAR, 0 = ramp; latched when start is accepted
//   start         conversion request, accepted only in IDLE with en=1
//   comp_in       asynchronous comparator output (1 = input above DAC)
//   dac_code      code driven to the DAC
//   busy          high while a conversion is in progress
//   result        last completed conversion
//   result_valid  single-cycle pulse when result updates
//
// Optional build macro:
//   CONV_AVG_EN   each start runs four conversions and reports their mean

module adc_conv_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sar_mode,
    input  logic             start,
    input  logic             comp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MSB_ONLY   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SETTLE, DECIDE, DONE} state_t;

    state_t           state, state_next;
    logic             comp_meta, comp_s;
    logic             mode_sar, mode_sar_next;
    logic [WIDTH-1:0] dac_code_next, result_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic [WIDTH-1:0] trial_bit;
    logic [WIDTH-1:0] kept_code;
    logic [WIDTH-1:0] final_code;
    logic [WIDTH-1:0] init_code;
    logic             conv_final;
    logic             last_iter;

    // The SAR trial bit is kept when the comparator says the input is above
    // the DAC level.  For the ramp the final code is simply the current code,
    // which also covers saturation at all-ones without wrapping to zero.
    assign trial_bit  = ONE << idx;
    assign kept_code  = comp_s ? dac_code : (dac_code & ~trial_bit);
    assign final_code = mode_sar ? kept_code : dac_code;
    assign conv_final = mode_sar ? (idx == '0) : (!comp_s || dac_code == ALL_ONES);
    assign init_code  = mode_sar ? MSB_ONLY : '0;

`ifdef CONV_AVG_EN
    logic [1:0]       iter, iter_next;
    logic [WIDTH+1:0] sum, sum_next, sum_plus;

    assign sum_plus  = sum + {2'b00, final_code};
    assign last_iter = (iter == 2'd3);
`else
    assign last_iter = 1'b1;
`endif

    // State and datapath registers, plus the two-flop comparator synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            comp_meta <= 1'b0;
            comp_s    <= 1'b0;
            mode_sar  <= 1'b0;
            dac_code  <= '0;
            result    <= '0;
            idx       <= '0;
            cnt       <= '0;
`ifdef CONV_AVG_EN
            iter      <= '0;
            sum       <= '0;
`endif
        end else begin
            state     <= state_next;
            comp_meta <= comp_in;
            comp_s    <= comp_meta;
            mode_sar  <= mode_sar_next;
            dac_code  <= dac_code_next;
            result    <= result_next;
            idx       <= idx_next;
            cnt       <= cnt_next;
`ifdef CONV_AVG_EN
            iter      <= iter_next;
            sum       <= sum_next;
`endif
        end
    end

    // Next-state and datapath logic.  Dropping en overrides every state and
    // abandons the conversion without touching the held result.
    always_comb begin
        state_next    = state;
        mode_sar_next = mode_sar;
        dac_code_next = dac_code;
        result_next   = result;
        idx_next      = idx;
        cnt_next      = cnt;
`ifdef CONV_AVG_EN
        iter_next     = iter;
        sum_next      = sum;
`endif
        if (!en) begin
            state_next    = IDLE;
            dac_code_next = '0;
`ifdef CONV_AVG_EN
            iter_next     = '0;
            sum_next      = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_sar_next = sar_mode;
                        dac_code_next = sar_mode ? MSB_ONLY : '0;
                        idx_next      = IDX_TOP;
                        cnt_next      = CNT_RELOAD;
                        state_next    = SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state_next = DECIDE;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                DECIDE: begin
                    if (conv_final) begin
                        dac_code_next = final_code;
                        state_next    = DONE;
`ifdef CONV_AVG_EN
                        sum_next      = sum_plus;
                        if (last_iter) begin
                            result_next = sum_plus[WIDTH+1:2];
                        end
`else
                        result_next   = final_code;
`endif
                    end else begin
                        if (mode_sar) begin
                            dac_code_next = kept_code | (trial_bit >> 1);
                            idx_next      = idx - 1'b1;
                        end else begin
                            dac_code_next = dac_code + 1'b1;
                        end
                        cnt_next   = CNT_RELOAD;
                        state_next = SETTLE;
                    end
                end
                DONE: begin
`ifdef CONV_AVG_EN
                    // Intermediate passes restart immediately in the latched mode.
                    if (!last_iter) begin
                        iter_next     = iter + 1'b1;
                        dac_code_next = init_code;
                        idx_next      = IDX_TOP;
                        cnt_next      = CNT_RELOAD;
                        state_next    = SETTLE;
                    end else begin
                        iter_next  = '0;
                        sum_next   = '0;
                        state_next = IDLE;
                    end
`else
                    state_next = IDLE;
`endif
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE) && last_iter;

endmodule

// File: tb/tb_adc_conv_ctrl.sv
// tb_adc_conv_ctrl
// Directed bench for adc_conv_ctrl (WIDTH=8, SETTLE_CYCLES=4).  A behavioural
// comparator (analog level > dac_code) feeds comp_in.  Expected results and
// latencies are pushed to a scoreboard when a start is issued and popped when
// result_valid appears.  Latency is counted in clock edges from the edge that
// accepts start to the edge that raises result_valid.

module tb_adc_conv_ctrl;

    localparam int W = 8;
    localparam int S = 4;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        string        tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         sar_mode;
    logic         start;
    logic         comp_in;
    logic [W-1:0] dac_code;
    logic         busy;
    logic [W-1:0] result;
    logic         result_valid;

    int           analog = 0;
    logic         tie_high = 1'b0;
    int           edge_cnt = 0;
    int           start_edge = 0;
    int           valid_count = 0;
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] last_result = '0;
    exp_t         sb[$];
    logic [W-1:0] trace[$];
    bit           tracing = 0;
    logic [W-1:0] sar_trials [8] = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};

    adc_conv_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .sar_mode     (sar_mode),
        .start        (start),
        .comp_in      (comp_in),
        .dac_code     (dac_code),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    // Clock and edge counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Comparator model: high while the analog level is above the DAC output.
    assign comp_in = tie_high | (analog > int'(dac_code));

    // Counts every result_valid pulse and records the trial codes of a
    // conversion while tracing is enabled.
    always @(negedge clk) begin
        if (result_valid === 1'b1) valid_count++;
        if (tracing && busy && !result_valid) begin
            if (trace.size() == 0 || trace[trace.size()-1] != dac_code) trace.push_back(dac_code);
        end
    end

    // Safety net so a stuck design still ends the run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] modelSar(input int level);
        logic [W-1:0] code = '0;
        for (int b = W - 1; b >= 0; b--) begin
            logic [W-1:0] trial = code | (W'(1) << b);
            if (level > int'(trial)) code = trial;
        end
        return code;
    endfunction

    function automatic logic [W-1:0] modelRamp(input int level, input logic tied);
        if (tied || level > 255) return 8'hFF;
        return W'(level);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one start pulse (raising en in the same cycle) and optionally
    // pushes the expected outcome onto the scoreboard.
    task automatic applyStimulus(input logic mode, input int level, input logic tied,
                                 input bit push, input string tag);
        exp_t e;
        @(negedge clk);
        en       = 1'b1;
        analog   = level;
        tie_high = tied;
        sar_mode = mode;
        start    = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        start_edge = edge_cnt;
        checkOutput({tag, "_busy_high"}, {31'b0, busy}, 32'd1);
        if (push) begin
            e.tag = tag;
            if (mode) begin
                e.res = modelSar(level);
                e.lat = W * (S + 1);
            end else begin
                e.res = modelRamp(level, tied);
                e.lat = (int'(e.res) + 1) * (S + 1);
            end
            sb.push_back(e);
        end
    endtask

    task automatic waitResult(input int budget);
        exp_t e;
        bit   got = 0;
        e = sb.pop_front();
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                got = 1;
                break;
            end
        end
        checkOutput({e.tag, "_valid_seen"}, {31'b0, got}, 32'd1);
        if (got) begin
            checkOutput({e.tag, "_result"}, {24'b0, result}, {24'b0, e.res});
            checkOutput({e.tag, "_latency"}, edge_cnt - start_edge, e.lat);
            @(negedge clk);
            checkOutput({e.tag, "_valid_single"}, {31'b0, result_valid}, 32'd0);
            checkOutput({e.tag, "_busy_low"}, {31'b0, busy}, 32'd0);
        end
        last_result = e.res;
    endtask

    task automatic checkTrace(input string tag);
        checkOutput({tag, "_trial_count"}, trace.size(), 8);
        for (int i = 0; i < 8 && i < trace.size(); i++) begin
            checkOutput($sformatf("%s_trial%0d", tag, i), {24'b0, trace[i]}, {24'b0, sar_trials[i]});
        end
    endtask

    initial begin
        int vc;
        exp_t e;
        reset    = 1'b1;
        en       = 1'b0;
        sar_mode = 1'b0;
        start    = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_dac_code", {24'b0, dac_code}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_result", {24'b0, result}, 32'd0);
        checkOutput("reset_valid", {31'b0, result_valid}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

`ifdef CONV_AVG_EN
        // Four SAR passes alternating between results 0x40 and 0x43.
        vc = valid_count;
        applyStimulus(1'b1, 'h41, 1'b0, 0, "avg");
        e.tag = "avg";
        e.res = W'((2 * int'(modelSar('h41)) + 2 * int'(modelSar('h44))) >> 2);
        e.lat = 4 * (1 + W * (S + 1)) - 1;
        sb.push_back(e);
        repeat (W * (S + 1)) @(negedge clk);
        analog = 'h44;
        repeat (1 + W * (S + 1)) @(negedge clk);
        analog = 'h41;
        repeat (1 + W * (S + 1)) @(negedge clk);
        analog = 'h44;
        waitResult(400);
        checkOutput("avg_single_pulse", valid_count - vc, 1);
`else
        // SAR conversion with trial-code trace.
        trace.delete();
        tracing = 1;
        applyStimulus(1'b1, 'h5B, 1'b0, 1, "sar");
        waitResult(200);
        tracing = 0;
        checkTrace("sar");

        // Ramp to level 3.
        applyStimulus(1'b0, 3, 1'b0, 1, "ramp3");
        waitResult(200);

        // Ramp with comparator stuck high saturates at all-ones.
        applyStimulus(1'b0, 0, 1'b1, 1, "ramp_sat");
        waitResult(1500);
        tie_high = 1'b0;

        // Start re-pulsed and mode toggled mid-conversion are ignored.
        trace.delete();
        tracing = 1;
        applyStimulus(1'b1, 'h5B, 1'b0, 1, "sar_repulse");
        repeat (5) @(negedge clk);
        start    = 1'b1;
        sar_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitResult(200);
        tracing = 0;
        checkTrace("sar_repulse");

        // Enable dropped mid-conversion aborts without a result.
        vc = valid_count;
        applyStimulus(1'b1, 'h20, 1'b0, 0, "en_drop");
        repeat (14) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checkOutput("en_drop_busy", {31'b0, busy}, 32'd0);
        checkOutput("en_drop_dac_code", {24'b0, dac_code}, 32'd0);
        checkOutput("en_drop_result_held", {24'b0, result}, {24'b0, last_result});
        checkOutput("en_drop_valid", {31'b0, result_valid}, 32'd0);
        repeat (50) @(negedge clk);
        checkOutput("en_drop_no_pulse", valid_count - vc, 0);

        // Reset mid-SETTLE returns every output to its reset value.
        applyStimulus(1'b1, 'h77, 1'b0, 0, "reset_mid");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid_dac_code", {24'b0, dac_code}, 32'd0);
        checkOutput("reset_mid_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_mid_result", {24'b0, result}, 32'd0);
        checkOutput("reset_mid_valid", {31'b0, result_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 'h5B, 1'b0, 1, "after_reset");
        waitResult(200);

        // en and start rising together are accepted.
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 2, 1'b0, 1, "en_start_same");
        waitResult(200);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
